// File: rtl/fft_frame_if.sv
// Bundle between the frame sequencer and its neighbours: the sample stream in,
// the fft launch/completion pair, the bin stream out, and the sticky status flags.
interface fft_frame_if #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int IW = $clog2(N);
  localparam int FW = DATA_WIDTH * N * 2;

  logic signed [DATA_WIDTH-1:0] sample_in;
  logic                         sample_valid;
  logic                         fft_en;
  logic [FW-1:0]                fft_data;
  logic                         fft_done;
  logic [FW-1:0]                fft_result;
  logic signed [DATA_WIDTH-1:0] bin_re;
  logic signed [DATA_WIDTH-1:0] bin_im;
  logic [IW-1:0]                bin_idx;
  logic                         bin_valid;
  logic                         bin_ready;
  logic                         frame_last;
  logic                         overrun;
  logic                         timeout_err;

  modport master (
    input  sample_in, sample_valid, fft_done, fft_result, bin_ready,
    output fft_en, fft_data, bin_re, bin_im, bin_idx, bin_valid,
           frame_last, overrun, timeout_err
  );

  modport slave (
    output sample_in, sample_valid, fft_done, fft_result, bin_ready,
    input  fft_en, fft_data, bin_re, bin_im, bin_idx, bin_valid,
           frame_last, overrun, timeout_err
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: fills an N-sample frame, launches the fft on it, waits for
// completion (with timeout) and streams the captured bins out one per handshake.
//
// state | meaning
// IDLE  | waiting for a complete frame in the fill buffer
// RUN   | fft_en high on the launch register, waiting for fft_done or timeout
// DRAIN | streaming captured bins 0..N-1 on bin_valid/bin_ready
module fft_frame_ctrl #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  fft_frame_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int FW = DATA_WIDTH * N * 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] fill_buf [N];
  logic [IW-1:0]                fill_cnt;
  logic [FW-1:0]                launch_q, launch_d, out_q;
  logic [TW-1:0]                tmo_cnt;
  logic [IW-1:0]                idx_q;
  logic                         frame_done, tmo_hit;
  logic                         load_launch, load_out, set_tmo, set_ovr, bin_acc;

  assign frame_done = bus.sample_valid && (fill_cnt == IW'(N - 1));
  assign tmo_hit    = (tmo_cnt == '0);

  // The completing sample is still in flight, so it is spliced in directly.
  always_comb begin
    launch_d = '0;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) launch_d[DATA_WIDTH*2*k +: DATA_WIDTH] = bus.sample_in;
      else            launch_d[DATA_WIDTH*2*k +: DATA_WIDTH] = fill_buf[k];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_launch = 1'b0;
    load_out    = 1'b0;
    set_tmo     = 1'b0;
    bin_acc     = 1'b0;
    set_ovr     = frame_done && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_done) begin
          load_launch = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (bus.fft_done) begin
          load_out = 1'b1;
          state_d  = DRAIN;
        end else if (tmo_hit) begin
          set_tmo = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.bin_ready) begin
          bin_acc = 1'b1;
          if (idx_q == IW'(N - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < N; k++) fill_buf[k] <= '0;
      fill_cnt <= '0;
    end else if (bus.sample_valid) begin
      fill_buf[fill_cnt] <= bus.sample_in;
      fill_cnt           <= fill_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      launch_q        <= '0;
      out_q           <= '0;
      tmo_cnt         <= '0;
      idx_q           <= '0;
      bus.overrun     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      if (load_launch) launch_q <= launch_d;
      if (load_out)    out_q    <= bus.fft_result;
      // Down-counter loaded at launch; terminal count 0 ends the RUN window.
      if (load_launch)                     tmo_cnt <= TW'(TIMEOUT - 1);
      else if (state_q == RUN && !tmo_hit) tmo_cnt <= tmo_cnt - TW'(1);
      if (load_out)     idx_q <= '0;
      else if (bin_acc) idx_q <= idx_q + IW'(1);
      if (set_ovr) bus.overrun     <= 1'b1;
      if (set_tmo) bus.timeout_err <= 1'b1;
    end
  end

  assign bus.fft_en     = (state_q == RUN);
  assign bus.fft_data   = launch_q;
  assign bus.bin_valid  = (state_q == DRAIN);
  assign bus.bin_idx    = idx_q;
  assign bus.frame_last = bus.bin_valid && (idx_q == IW'(N - 1));
  assign bus.bin_re     = bus.bin_valid ? out_q[DATA_WIDTH*(2*int'(idx_q))   +: DATA_WIDTH] : '0;
  assign bus.bin_im     = bus.bin_valid ? out_q[DATA_WIDTH*(2*int'(idx_q)+1) +: DATA_WIDTH] : '0;
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer for the fft datapath. It accumulates a serial stream of real audio samples into an N-point frame and launches the fft on that frame by holding fft_en and a stable packed input word. It waits for the fft's completion strobe, captures the bin-ordered result (after fft_sorter), and streams the bins out one per handshake. Sits between the audio front end and any spectrum consumer; the fft and fft_sorter are instantiated beside it.

Parameters:
N, 16, FFT points per frame (power of two, >=4)
DATA_WIDTH, 16, signed width of each real/imag component
TIMEOUT, 1024, max clk cycles from launch to fft_done before abort

Ports:
clk  in  1  system clock (the fft's clock)
n_rst  in  1  asynchronous active-low reset
sample_in  in  DATA_WIDTH  signed real audio sample
sample_valid  in  1  one-cycle strobe, sample_in valid
fft_en  out  1  enable to fft
fft_data  out  DATA_WIDTH*N*2  packed frame to fft cplx_data_in
fft_done  in  1  fft en_out
fft_result  in  DATA_WIDTH*N*2  packed natural-order bins from fft_sorter
bin_re  out  DATA_WIDTH  current bin real part
bin_im  out  DATA_WIDTH  current bin imag part
bin_idx  out  log2(N)  current bin index
bin_valid  out  1  bin outputs valid
bin_ready  in  1  consumer accepts bin
frame_last  out  1  high with bin_idx==N-1 while bin_valid
overrun  out  1  sticky: a full frame was dropped
timeout_err  out  1  sticky: fft_done not seen within TIMEOUT

Behaviour:
- Packing (fft_data and fft_result): element k real = [DATA_WIDTH*(2k+1)-1 -: DATA_WIDTH], imag = [DATA_WIDTH*(2k+2)-1 -: DATA_WIDTH]. Sample n of the frame goes to element n; imag = 0.
- Reset (async, n_rst low): all outputs 0; fill count 0; FSM IDLE; fill buffer and launch register cleared. Reset mid-operation abandons the frame. fft_en drops immediately.
- Fill buffer (runs in every state): each sample_valid writes sample_in to slot fill_cnt, and fill_cnt increments. On the write into slot N-1 the frame is complete and fill_cnt wraps to 0 in the same cycle.
  - If FSM is IDLE on that cycle, the complete frame, including the current sample, is copied to the launch register next edge.
  - Otherwise the frame is discarded and overrun is set.
- FSM:
  - IDLE: wait for frame-complete. Copy to launch register, then go to RUN.
  - RUN: fft_data = launch register, stable until the next launch. fft_en = 1 from the first RUN cycle. The timeout counter counts from 0.
    - On fft_done = 1: latch fft_result into the output register, fft_en = 0 next cycle, go to DRAIN with bin index 0.
    - If the counter reaches TIMEOUT-1 without fft_done: set timeout_err, fft_en = 0, go to IDLE.
  - DRAIN: bin_valid = 1; bin_re/bin_im/bin_idx show the output register element bin_idx.
    - Outputs are held stable while bin_valid && !bin_ready.
    - On bin_valid && bin_ready, advance the index. Accepting index N-1 returns to IDLE with bin_valid = 0 the next cycle. No bubble between consecutive bins.
- Launch latency: frame-complete cycle +1 → fft_en high. fft_done cycle +1 → first bin_valid.
- fft_done outside RUN is ignored. sample_valid on the same cycle as a state change is never lost from the fill buffer.
- overrun and timeout_err clear only on reset.
- Fill and DRAIN proceed concurrently. A frame completing during DRAIN is an overrun.

Test Plan:
- Reset: hold n_rst low with sample_valid toggling → all outputs 0. Release → fill_cnt starts at 0; the first N samples form frame 0.
- Basic frame, N=16: samples 1000,0,0,0,-1000,0,0,0 repeated, with the real fft+fft_sorter → fft_en high one cycle after the 16th strobe; fft_data element 0 real = 1000, element 4 real = -1000; 16 bins stream idx 0..15; nonzero only at idx 2,6,10,14 (equal magnitude); frame_last at idx 15.
- Backpressure: bin_ready low for 5 cycles at idx 3 → idx 3 and its data held stable; then idx 4 follows with no gap once ready.
- Overrun: samples every cycle with bin_ready held low → the second full frame is dropped, overrun = 1. After ready releases, the third frame launches normally.
- Timeout: fft model never asserts fft_done → timeout_err = 1 exactly TIMEOUT cycles after fft_en rose; fft_en low; FSM accepts the next frame.
- Async reset mid-DRAIN at idx 7 → bin_valid and fft_en low immediately; no further bins after release until a new full frame.
